prefetch_queue: RTL and testbench

Instruction prefetch stage between the program memory port and the decoder. It fetches 16-bit words ahead of execution into a small circular queue and presents 32-bit instructions to the decoder, one per `ir_valid`/`ir_ready` handshake. It also reports the PC of the presented instruction. A flush from the fetch/branch logic discards queued words and restarts fetching at a new word address.

---
 rtl/pq_pkg.sv | 21 ++
 rtl/pq_store.sv | 42 ++++
 rtl/prefetch_queue.sv | 143 ++++++++++++++
 tb/tb_prefetch_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pq_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned INSTR_W = 32;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } pq_state_e;

    // Instruction as presented to the decoder: first fetched word in the upper half.
    typedef struct packed {
        logic [WORD_W-1:0] first;
        logic [WORD_W-1:0] second;
    } pq_instr_t;

endpackage

// File: rtl/pq_store.sv
// Circular word store for the prefetch queue: one write port, two adjacent read ports.
module pq_store
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [PW-1:0]     wp,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PW-1:0]     rd,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_plus1;

    assign rd_plus1 = rd + PW'(1);

    // Clear takes priority so a flush never lets a late word land in the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wp] <= wdata;
        end
    end

    assign rdata0 = mem[rd];
    assign rdata1 = mem[rd_plus1];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch stage: fetches 16-bit words ahead and presents 32-bit instructions.
module prefetch_queue
    import pq_pkg::*;
#(
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ready,
    input  logic [WORD_W-1:0]  mem_rdata,
    input  logic               flush,
    input  logic [AW-1:0]      flush_addr,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [AW-1:0]      ir_pc
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] TWO  = CW'(2);

    pq_state_e         state, state_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [PW-1:0]     wp, wp_nxt;
    logic [PW-1:0]     rd, rd_nxt;
    logic [AW-1:0]     fetch_pc, fetch_pc_nxt;
    logic [AW-1:0]     ir_pc_nxt;
    logic [AW-1:0]     mem_addr_nxt;
    logic              wr_en;
    logic              consume;
    logic [WORD_W-1:0] q0, q1;
    pq_instr_t         instr;

    assign consume = ir_valid & ir_ready & ~flush;

    // Next-state, pointer, counter and PC logic; flush overrides everything else.
    always_comb begin
        state_nxt    = state;
        wr_en        = 1'b0;
        count_nxt    = count;
        wp_nxt       = wp;
        rd_nxt       = rd;
        fetch_pc_nxt = fetch_pc;
        ir_pc_nxt    = ir_pc;
        mem_addr_nxt = mem_addr;

        case (state)
            IDLE: begin
                if (count < FULL && !flush) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_nxt = mem_ready ? IDLE : DROP;
                end else if (mem_ready) begin
                    wr_en = 1'b1;
                end
            end
            DROP: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (wr_en) begin
            wp_nxt       = wp + PW'(1);
            fetch_pc_nxt = fetch_pc + AW'(1);
        end
        if (consume) begin
            rd_nxt    = rd + PW'(2);
            ir_pc_nxt = ir_pc + AW'(2);
        end
        count_nxt = count + CW'(wr_en) - (consume ? TWO : CW'(0));

        // Space is checked after the write so requests can run back to back.
        if (wr_en) begin
            state_nxt = (count_nxt < FULL) ? REQ : IDLE;
        end

        if (flush) begin
            count_nxt    = '0;
            wp_nxt       = '0;
            rd_nxt       = '0;
            fetch_pc_nxt = flush_addr;
            ir_pc_nxt    = flush_addr;
        end

        // An abandoned request keeps its address until the memory answers.
        mem_addr_nxt = (state_nxt == DROP) ? mem_addr : fetch_pc_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            wp       <= '0;
            rd       <= '0;
            fetch_pc <= RESET_PC;
            ir_pc    <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            wp       <= wp_nxt;
            rd       <= rd_nxt;
            fetch_pc <= fetch_pc_nxt;
            ir_pc    <= ir_pc_nxt;
            mem_addr <= mem_addr_nxt;
            mem_req  <= (state_nxt != IDLE);
            ir_valid <= (count_nxt >= TWO);
        end
    end

    pq_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .we     (wr_en),
        .wp     (wp),
        .wdata  (mem_rdata),
        .rd     (rd),
        .rdata0 (q0),
        .rdata1 (q1)
    );

    assign instr.first  = q0;
    assign instr.second = q1;
    assign ir           = instr;

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomised scoreboard bench for prefetch_queue against an address-stream reference model.
module tb_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        flush;
    logic [15:0] flush_addr;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_pc;

    prefetch_queue #(
        .DEPTH    (4),
        .AW       (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .flush_addr (flush_addr),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_pc      (ir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] gen_pc;
    logic [15:0] req_log[$];
    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          junk_en = 1'b0;

    // Program memory contents: distinct word per address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: consecutive 2-word instructions from the last redirect address.
    task automatic refill();
        exp_t e;
        while (exp_q.size() < 4) begin
            e.pc = gen_pc;
            e.ir = {mem_word(gen_pc), mem_word(16'(gen_pc + 16'd1))};
            exp_q.push_back(e);
            gen_pc = 16'(gen_pc + 16'd2);
        end
    endtask

    task automatic model_restart(input logic [15:0] a);
        exp_q.delete();
        gen_pc = a;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: random latency, checks request stability, junk ready while idle.
    initial begin
        bit          pending;
        logic [15:0] hold_addr;
        int          cnt;
        int          cur_lat;
        pending   = 1'b0;
        hold_addr = '0;
        cnt       = 0;
        cur_lat   = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            step();
            mem_ready = 1'b0;
            if (!reset) begin
                pending = 1'b0;
            end else if (mem_req) begin
                if (!pending) begin
                    pending   = 1'b1;
                    hold_addr = mem_addr;
                    cnt       = 0;
                    cur_lat   = int'($urandom_range(lat_hi, lat_lo));
                end else begin
                    chk("req_addr_stable", 32'(mem_addr), 32'(hold_addr));
                end
                if (cnt >= cur_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    req_log.push_back(mem_addr);
                    pending   = 1'b0;
                end else begin
                    cnt++;
                end
            end else if (junk_en && $urandom_range(3, 0) == 0) begin
                mem_ready = 1'b1;
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted instruction; watches for starvation.
    initial begin
        exp_t e;
        int   stall;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!reset || flush || ir_valid) begin
                stall = 0;
            end else begin
                stall++;
                if (stall > 60) begin
                    chk("ir_valid_timeout", 32'(ir_valid), 32'd1);
                    stall = 0;
                end
            end
            if (reset && ir_valid && ir_ready && !flush) begin
                hs_cnt++;
                refill();
                e = exp_q.pop_front();
                chk("hs_ir_pc", 32'(ir_pc), 32'(e.pc));
                chk("hs_ir", ir, e.ir);
                refill();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int hs0;
        reset      = 1'b0;
        flush      = 1'b0;
        flush_addr = '0;
        ir_ready   = 1'b0;
        gen_pc     = '0;
        model_restart(16'h0000);

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_pc", 32'(ir_pc), 32'h0000);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("rst_ir", ir, 32'h0);

        // Fill to full with one-cycle memory latency and no consumer
        step();
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_log.size() == 4 && !mem_req) break;
        end
        chk("fill_log_size", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_log.size()) chk("fill_addr", 32'(req_log[i]), 32'(i));
        end
        chk("full_mem_req", 32'(mem_req), 32'd0);
        chk("full_ir_valid", 32'(ir_valid), 32'd1);
        chk("full_ir", ir, {mem_word(16'd0), mem_word(16'd1)});
        chk("full_ir_pc", 32'(ir_pc), 32'd0);

        // Single consume from full
        step();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        @(negedge clk);
        chk("pop_ir_pc", 32'(ir_pc), 32'd2);
        chk("pop_ir", ir, {mem_word(16'd2), mem_word(16'd3)});
        for (int i = 0; i < 10; i++) begin
            if (mem_req) break;
            @(negedge clk);
        end
        chk("refetch_addr", 32'(mem_addr), 32'd4);
        chk("refetch_req", 32'(mem_req), 32'd1);

        // Flush while the request to 5 is stalled
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'd5) break;
        end
        chk("stall_addr5", 32'(mem_addr), 32'd5);
        step();
        flush      = 1'b1;
        flush_addr = 16'h0100;
        model_restart(16'h0100);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("drop_ir_valid", 32'(ir_valid), 32'd0);
        chk("drop_ir_pc", 32'(ir_pc), 32'h0100);
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_addr != 16'd5) break;
            @(negedge clk);
        end
        chk("after_drop_addr", 32'(mem_addr), 32'h0100);
        for (int i = 0; i < 40; i++) begin
            if (ir_valid) break;
            @(negedge clk);
        end
        chk("redir_ir_valid", 32'(ir_valid), 32'd1);
        chk("redir_ir_pc", 32'(ir_pc), 32'h0100);
        chk("redir_ir", ir, {mem_word(16'h0100), mem_word(16'h0101)});

        // Flush in the same cycle a word arrives
        lat_lo = 0;
        lat_hi = 0;
        found  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            #1;
            if (mem_req && mem_ready) begin
                flush      = 1'b1;
                flush_addr = 16'h0200;
                model_restart(16'h0200);
                found = 1'b1;
                break;
            end
        end
        chk("flush_ready_found", 32'(found), 32'd1);
        step();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("flush_ready_next_addr", 32'(mem_addr), 32'h0200);
        for (int i = 0; i < 40; i++) begin
            if (ir_valid) break;
            @(negedge clk);
        end
        chk("flush_ready_ir", ir, {mem_word(16'h0200), mem_word(16'h0201)});
        chk("flush_ready_ir_pc", 32'(ir_pc), 32'h0200);

        // Instruction straddling the top of the address space
        step();
        flush      = 1'b1;
        flush_addr = 16'hFFFF;
        model_restart(16'hFFFF);
        step();
        flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ir_valid) break;
        end
        chk("wrap_ir_pc", 32'(ir_pc), 32'hFFFF);
        chk("wrap_ir", ir, {mem_word(16'hFFFF), mem_word(16'h0000)});
        step();
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        @(negedge clk);
        chk("wrap_next_pc", 32'(ir_pc), 32'h0001);

        // Random traffic
        lat_lo  = 0;
        lat_hi  = 3;
        junk_en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            step();
            flush = ($urandom_range(39, 0) == 0);
            if (flush) begin
                flush_addr = ($urandom_range(3, 0) == 0) ? 16'(16'hFFFC + $urandom_range(3, 0))
                                                         : 16'($urandom);
                model_restart(flush_addr);
            end
            ir_ready = ($urandom_range(9, 0) < 7);
        end
        step();
        flush    = 1'b0;
        ir_ready = 1'b0;
        junk_en  = 1'b0;

        // Asynchronous reset in the middle of a request
        lat_lo = 2;
        lat_hi = 2;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req) break;
        end
        #2;
        reset = 1'b0;
        model_restart(16'h0000);
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_ir_valid", 32'(ir_valid), 32'd0);
        chk("async_ir_pc", 32'(ir_pc), 32'h0000);
        chk("async_ir", ir, 32'h0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("restart_addr", 32'(mem_addr), 32'h0000);
        hs0      = hs_cnt;
        ir_ready = 1'b1;
        repeat (40) step();
        ir_ready = 1'b0;
        chk("restart_stream", 32'(hs_cnt > hs0), 32'd1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
